// File: rtl/seq_input_conditioner.sv
// seq_input_conditioner: synchronizes and debounces a raw multi-bit code and
// hands each newly accepted code downstream over a valid/ready handshake.
`default_nettype none

module seq_input_conditioner #(
  parameter int WIDTH           = 7,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [WIDTH-1:0] m_sequence_raw,
  output logic [WIDTH-1:0] seq_code,
  output logic             seq_valid,
  input  logic             seq_ready,
  output logic             seq_overrun,
  output logic             busy
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;
  logic             load_cand;
  logic             inc_cnt;
  logic             emit;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= m_sequence_raw;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_cand  = 1'b0;
    inc_cnt    = 1'b0;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        if (s != acc) begin
          load_cand  = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (s != cand) begin
          load_cand = 1'b1;
        end else if (cnt < CNT_MAX) begin
          inc_cnt = 1'b1;
        end else begin
          // A candidate equal to acc means the input glitched and came back.
          emit       = (cand != acc);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cand        <= '0;
      cnt         <= '0;
      acc         <= '0;
      seq_code    <= '0;
      seq_valid   <= 1'b0;
      seq_overrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (load_cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (inc_cnt) begin
        cnt <= cnt + CW'(1);
      end
      if (emit) begin
        acc      <= cand;
        seq_code <= cand;
      end
      seq_valid   <= emit | (seq_valid & ~seq_ready);
      // Overrun only when the pending code is lost, not when it leaves this edge.
      seq_overrun <= emit & seq_valid & ~seq_ready;
      busy        <= (state_next == SETTLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_input_conditioner.sv
// tb_seq_input_conditioner: directed steps with a code scoreboard popped on
// every valid/ready transfer, for DEBOUNCE_CYCLES=4.
`default_nettype none

module tb_seq_input_conditioner;

  localparam int WIDTH = 7;
  localparam int DEB   = 4;

  logic             clk;
  logic             nRst;
  logic [WIDTH-1:0] m_sequence_raw;
  logic [WIDTH-1:0] seq_code;
  logic             seq_valid;
  logic             seq_ready;
  logic             seq_overrun;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int busy_seen = 0;
  int overrun_seen = 0;
  int v0, b0, o0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_code;

  seq_input_conditioner #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk),
    .nRst(nRst),
    .m_sequence_raw(m_sequence_raw),
    .seq_code(seq_code),
    .seq_valid(seq_valid),
    .seq_ready(seq_ready),
    .seq_overrun(seq_overrun),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Any transfer in the coming edge must carry the oldest expected code.
  always @(negedge clk) begin
    if (seq_valid) valid_cycles++;
    if (busy) busy_seen++;
    if (seq_overrun) overrun_seen++;
    if (nRst && seq_valid && seq_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected observed %0h expected none", seq_code);
      end else begin
        exp_code = exp_q.pop_front();
        assert (seq_code === exp_code)
        else begin
          errors++;
          $error("FAIL sb_code observed %0h expected %0h", seq_code, exp_code);
        end
      end
    end
  end

  initial begin
    nRst           = 1'b0;
    m_sequence_raw = '0;
    seq_ready      = 1'b1;

    // Reset state, then quiet input
    tick(2);
    chk("rst_code", 32'(seq_code), 0);
    chk("rst_valid", 32'(seq_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(seq_overrun), 0);
    nRst = 1'b1;
    v0 = valid_cycles; b0 = busy_seen;
    tick(50);
    chk("idle_valid_cnt", 32'(valid_cycles - v0), 0);
    chk("idle_busy_cnt", 32'(busy_seen - b0), 0);
    chk("idle_code", 32'(seq_code), 0);
    chk("idle_ovr", 32'(seq_overrun), 0);

    // First code, latency DEB+3 edges, ready=1
    v0 = valid_cycles;
    m_sequence_raw = 7'b1100100;
    exp_q.push_back(7'b1100100);
    tick(DEB + 2);
    chk("lat_early_valid", 32'(seq_valid), 0);
    tick(1);
    chk("lat_valid", 32'(seq_valid), 1);
    chk("lat_code", 32'(seq_code), 32'h64);
    tick(1);
    chk("lat_xfer_clear", 32'(seq_valid), 0);
    tick(20);
    chk("lat_one_valid", 32'(valid_cycles - v0), 1);
    chk("lat_busy_end", 32'(busy), 0);

    // Glitch that returns to the accepted value
    m_sequence_raw = 7'b0000001;
    exp_q.push_back(7'b0000001);
    tick(10);
    v0 = valid_cycles; b0 = busy_seen;
    m_sequence_raw = 7'b0000011;
    tick(3);
    m_sequence_raw = 7'b0000001;
    tick(15);
    chk("glitch_no_valid", 32'(valid_cycles - v0), 0);
    chk("glitch_busy_seen", 32'(busy_seen > b0), 1);
    chk("glitch_busy_end", 32'(busy), 0);

    // Overrun: pending 0x12 overwritten by 0x34 with ready low
    seq_ready = 1'b0;
    m_sequence_raw = 7'h12;
    tick(8);
    chk("ovr_pend_valid", 32'(seq_valid), 1);
    chk("ovr_pend_code", 32'(seq_code), 32'h12);
    m_sequence_raw = 7'h34;
    exp_q.push_back(7'h34);
    o0 = overrun_seen;
    tick(DEB + 2);
    chk("ovr_before", 32'(seq_overrun), 0);
    chk("ovr_hold_code", 32'(seq_code), 32'h12);
    tick(1);
    chk("ovr_pulse", 32'(seq_overrun), 1);
    chk("ovr_code", 32'(seq_code), 32'h34);
    chk("ovr_valid", 32'(seq_valid), 1);
    tick(1);
    chk("ovr_pulse_end", 32'(seq_overrun), 0);
    chk("ovr_once", 32'(overrun_seen - o0), 1);
    seq_ready = 1'b1;
    tick(1);
    chk("ovr_xfer_clear", 32'(seq_valid), 0);
    tick(5);

    // Emit coincident with transfer of pending code
    seq_ready = 1'b0;
    m_sequence_raw = 7'h12;
    exp_q.push_back(7'h12);
    tick(DEB + 3);
    chk("coin_pend_valid", 32'(seq_valid), 1);
    chk("coin_pend_code", 32'(seq_code), 32'h12);
    m_sequence_raw = 7'h34;
    exp_q.push_back(7'h34);
    o0 = overrun_seen;
    tick(DEB + 2);
    seq_ready = 1'b1;
    tick(1);
    chk("coin_valid", 32'(seq_valid), 1);
    chk("coin_code", 32'(seq_code), 32'h34);
    chk("coin_ovr", 32'(seq_overrun), 0);
    tick(1);
    chk("coin_clear", 32'(seq_valid), 0);
    chk("coin_no_ovr", 32'(overrun_seen - o0), 0);
    tick(5);

    // Async reset during SETTLE at cnt=2, then re-acceptance
    m_sequence_raw = 7'h55;
    tick(5);
    chk("rs_busy", 32'(busy), 1);
    #2 nRst = 1'b0;
    #1;
    chk("rs_async_busy", 32'(busy), 0);
    chk("rs_async_valid", 32'(seq_valid), 0);
    chk("rs_async_code", 32'(seq_code), 0);
    chk("rs_async_ovr", 32'(seq_overrun), 0);
    #1 nRst = 1'b1;
    exp_q.push_back(7'h55);
    tick(DEB + 2);
    chk("rs_early_valid", 32'(seq_valid), 0);
    tick(1);
    chk("rs_valid", 32'(seq_valid), 1);
    chk("rs_code", 32'(seq_code), 32'h55);
    tick(1);
    chk("rs_clear", 32'(seq_valid), 0);
    tick(3);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
